// File: rtl/opb_ppc2user_pkg.sv
// Purpose: shared constants for the PPC-to-user write FIFO register block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: register word offsets, STATUS/CONTROL bit positions, bus FSM states.
package opb_ppc2user_pkg;

    // Word offsets within the 256-byte window (byte offset >> 2).
    localparam logic [5:0] REG_DATA    = 6'd0;
    localparam logic [5:0] REG_STATUS  = 6'd1;
    localparam logic [5:0] REG_CONTROL = 6'd2;
    localparam logic [5:0] REG_PUSHCNT = 6'd3;

    // STATUS register bit positions (the fill count sits in the low bits).
    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_EMPTY_BIT = 17;
    localparam int STAT_FULL_BIT  = 16;

    // CONTROL register bit positions (write-one actions).
    localparam int CTRL_CLR_OVF_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Purpose: single-clock first-word-fall-through FIFO; head word is visible on dout while non-empty.
// Latency: a pushed word appears on dout the cycle after the push edge.
// Backpressure: push ignored when full (even with a same-cycle pop); pop ignored when empty; flush wins over pop.
// Ports: push/pop/flush strobes, din/dout data, count (0..2^AW), full, empty.
module sync_fifo_fwft #(
    parameter int W  = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never opens room for a push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opb_register_ppc2user_fifo.sv
// Purpose: OPB slave letting the PPC push 32-bit words into a FWFT FIFO drained by user logic.
// Latency: Sl_xferAck one cycle after select is first seen; pushed word visible to user one cycle after ack edge.
// Backpressure: user side valid/ready; bus writes to a full FIFO are dropped and flagged as overflow.
// Ports: OPB slave (ABus/BE/DBus/RNW/select in, Sl_* out), user_data_out/user_valid out, user_ready in.
module opb_register_ppc2user_fifo
    import opb_ppc2user_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01002200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010022FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          FIFO_AW      = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [31:0]               user_data_out,
    output logic                      user_valid,
    input  logic                      user_ready
);

    // Bus vectors are big-endian numbered; plain assignment maps bus bit
    // [31-i] onto register bit i.
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic [5:0]       word_off;
    logic [31:0]      wdata_masked;
    logic [31:0]      rd_mux;

    bus_state_t       state;
    logic             sl_xfer_ack;
    logic [31:0]      sl_dbus;
    logic             overflow;
    logic [31:0]      push_cnt;

    logic             hit;
    logic             take;
    logic             push_req;
    logic             ctrl_wr;
    logic             flush;
    logic             ovf_clr;

    logic [31:0]      fifo_dout;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             unused_ok;

    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be       = OPB_BE;
    assign word_off = OPB_ABus[24:29];

    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // Side effects fire only on the IDLE->ACK edge, so each transaction acts once.
    assign take     = (state == BUS_IDLE) && hit;
    assign push_req = take && !OPB_RNW && (word_off == REG_DATA);
    assign ctrl_wr  = take && !OPB_RNW && (word_off == REG_CONTROL);
    assign flush    = ctrl_wr && wdata[CTRL_FLUSH_BIT];
    assign ovf_clr  = ctrl_wr && wdata[CTRL_CLR_OVF_BIT];

    assign unused_ok = OPB_seqAddr ^ (C_FAMILY == "virtex6");

    // be[k] covers register byte k; disabled bytes are stored as zero.
    always_comb begin
        wdata_masked = '0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) wdata_masked[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word_off)
            REG_STATUS: begin
                rd_mux[STAT_OVF_BIT]   = overflow;
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[FIFO_AW:0]      = fifo_count;
            end
            REG_PUSHCNT: rd_mux = push_cnt;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state       <= BUS_IDLE;
            sl_xfer_ack <= 1'b0;
            sl_dbus     <= '0;
            overflow    <= 1'b0;
            push_cnt    <= '0;
        end else begin
            sl_xfer_ack <= 1'b0;
            sl_dbus     <= '0;
            case (state)
                BUS_IDLE: begin
                    if (hit) begin
                        state       <= BUS_ACK;
                        sl_xfer_ack <= 1'b1;
                        sl_dbus     <= OPB_RNW ? rd_mux : 32'h0;
                    end
                end
                BUS_ACK: state <= BUS_IDLE;
                default: state <= BUS_IDLE;
            endcase

            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end

            if (push_req && !fifo_full) begin
                push_cnt <= push_cnt + 32'd1;
            end
        end
    end

    sync_fifo_fwft #(
        .W  (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .push  (push_req),
        .pop   (user_ready),
        .flush (flush),
        .din   (wdata_masked),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign Sl_DBus       = sl_dbus;
    assign Sl_xferAck    = sl_xfer_ack;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = fifo_dout;
    assign user_valid    = ~fifo_empty;

endmodule

// File: tb/tb_opb_register_ppc2user_fifo.sv
// Purpose: directed self-checking bench for opb_register_ppc2user_fifo.
// Latency: n/a.
// Backpressure: n/a.
module tb_opb_register_ppc2user_fifo;

    localparam logic [31:0] BASE = 32'h01002200;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n = 1'b0;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = '0;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b1;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_out;
    logic        user_valid;
    logic        user_ready = 1'b0;

    opb_register_ppc2user_fifo dut (
        .OPB_Clk       (OPB_Clk),
        .OPB_Rst_n     (OPB_Rst_n),
        .OPB_ABus      (OPB_ABus),
        .OPB_BE        (OPB_BE),
        .OPB_DBus      (OPB_DBus),
        .OPB_RNW       (OPB_RNW),
        .OPB_select    (OPB_select),
        .OPB_seqAddr   (OPB_seqAddr),
        .Sl_DBus       (Sl_DBus),
        .Sl_xferAck    (Sl_xferAck),
        .Sl_errAck     (Sl_errAck),
        .Sl_retry      (Sl_retry),
        .Sl_toutSup    (Sl_toutSup),
        .user_data_out (user_data_out),
        .user_valid    (user_valid),
        .user_ready    (user_ready)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] popped [$];

    // Record each word the consumer takes, sampled just before the popping edge.
    always @(negedge OPB_Clk) begin
        #4;
        if (user_valid && user_ready) popped.push_back(user_data_out);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One OPB transaction; lat = cycles from select to ack, or -1 if none within 4.
    task automatic bus_xfer(input logic [31:0] a, input logic rnw, input logic [3:0] b,
                            input logic [31:0] wd, input logic rdy,
                            output logic [31:0] rdata, output int lat);
        @(negedge OPB_Clk);
        OPB_ABus   = a;
        OPB_RNW    = rnw;
        OPB_BE     = b;
        OPB_DBus   = wd;
        OPB_select = 1'b1;
        user_ready = rdy;
        lat   = -1;
        rdata = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge OPB_Clk);
            #1;
            if (Sl_xferAck) begin
                lat   = c;
                rdata = Sl_DBus;
                break;
            end
        end
        OPB_select = 1'b0;
        OPB_RNW    = 1'b1;
        OPB_DBus   = '0;
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        logic [31:0] d;
        int l;
        bus_xfer(BASE + {24'h0, off}, 1'b1, 4'hF, 32'h0, 1'b0, d, l);
        check({name, "_lat"}, l, 1);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic rdy, input string name);
        logic [31:0] d;
        int l;
        bus_xfer(BASE + {24'h0, off}, 1'b0, 4'hF, wd, rdy, d, l);
        check({name, "_lat"}, l, 1);
    endtask

    task automatic do_reset();
        OPB_select = 1'b0;
        user_ready = 1'b0;
        OPB_Rst_n  = 1'b0;
        @(negedge OPB_Clk);
        @(negedge OPB_Clk);
        OPB_Rst_n = 1'b1;
        popped.delete();
    endtask

    task automatic wait_pops(input int n);
        for (int c = 0; c < 40 && popped.size() < n; c++) @(negedge OPB_Clk);
    endtask

    typedef struct {
        logic [7:0]  off;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_head;
        logic        pop_after;
        string       name;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] d;
        int l;

        vecs[0]  = '{8'h04, 1'b1, 4'hF, 32'h0,        32'h00020000, 1'b0, 32'h0,        1'b0, "v0_status_rst"};
        vecs[1]  = '{8'h0C, 1'b1, 4'hF, 32'h0,        32'h00000000, 1'b0, 32'h0,        1'b0, "v1_pushcnt_rst"};
        vecs[2]  = '{8'h00, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "v2_wr_data"};
        vecs[3]  = '{8'h04, 1'b1, 4'hF, 32'h0,        32'h00000001, 1'b1, 32'hDEADBEEF, 1'b1, "v3_status_one"};
        vecs[4]  = '{8'h04, 1'b1, 4'hF, 32'h0,        32'h00020000, 1'b0, 32'h0,        1'b0, "v4_status_popped"};
        vecs[5]  = '{8'h00, 1'b0, 4'hA, 32'h12345678, 32'h0,        1'b1, 32'h12005600, 1'b0, "v5_wr_be1010"};
        vecs[6]  = '{8'h14, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h12005600, 1'b0, "v6_wr_unmapped"};
        vecs[7]  = '{8'h10, 1'b1, 4'hF, 32'h0,        32'h00000000, 1'b1, 32'h12005600, 1'b0, "v7_rd_unmapped"};
        vecs[8]  = '{8'h00, 1'b1, 4'hF, 32'h0,        32'h00000000, 1'b1, 32'h12005600, 1'b0, "v8_rd_data"};
        vecs[9]  = '{8'h08, 1'b1, 4'hF, 32'h0,        32'h00000000, 1'b1, 32'h12005600, 1'b0, "v9_rd_control"};
        vecs[10] = '{8'h0C, 1'b1, 4'hF, 32'h0,        32'h00000002, 1'b1, 32'h12005600, 1'b1, "v10_pushcnt"};
        vecs[11] = '{8'hFC, 1'b1, 4'hF, 32'h0,        32'h00000000, 1'b0, 32'h0,        1'b0, "v11_rd_top"};

        // Reset state
        #1;
        check("rst_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("rst_dbus", Sl_DBus, 32'h0);
        check("rst_valid", {31'h0, user_valid}, 32'h0);
        check("tied_zero", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        do_reset();

        // Table-driven single transactions
        for (int i = 0; i < 12; i++) begin
            bus_xfer(BASE + {24'h0, vecs[i].off}, vecs[i].rnw, vecs[i].be, vecs[i].wdata, 1'b0, d, l);
            check({vecs[i].name, "_lat"}, l, 1);
            if (vecs[i].rnw) check({vecs[i].name, "_rd"}, d, vecs[i].exp_rd);
            check({vecs[i].name, "_valid"}, {31'h0, user_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) check({vecs[i].name, "_head"}, user_data_out, vecs[i].exp_head);
            if (vecs[i].pop_after) begin
                @(negedge OPB_Clk) user_ready = 1'b1;
                @(negedge OPB_Clk) user_ready = 1'b0;
            end
        end
        check("dbus_idle_zero", Sl_DBus, 32'h0);

        // Out-of-window addresses get no ack
        bus_xfer(BASE - 32'd4, 1'b1, 4'hF, 32'h0, 1'b0, d, l);
        check("below_window_noack", l, -1);
        bus_xfer(BASE + 32'h100, 1'b1, 4'hF, 32'h0, 1'b0, d, l);
        check("above_window_noack", l, -1);

        // Overflow: 17 writes, drain 16 in order, clear overflow
        do_reset();
        for (int i = 0; i < 17; i++) wr(8'h00, i, 1'b0, "ovf_fill");
        rd(8'h04, 32'h80010010, "ovf_status");
        rd(8'h0C, 32'd16, "ovf_pushcnt");
        popped.delete();
        @(negedge OPB_Clk) user_ready = 1'b1;
        wait_pops(16);
        user_ready = 1'b0;
        check("ovf_drain_cnt", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++) check("ovf_drain_word", popped[i], i);
        check("ovf_drain_valid", {31'h0, user_valid}, 32'h0);
        wr(8'h08, 32'h1, 1'b0, "ovf_clr");
        rd(8'h04, 32'h00020000, "ovf_cleared_status");

        // Full with user_ready held: extra push dropped despite same-cycle pop
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'h00, 32'h100 + i, 1'b0, "full_fill");
        popped.delete();
        wr(8'h00, 32'h00000BAD, 1'b1, "full_extra");
        wait_pops(16);
        @(negedge OPB_Clk) user_ready = 1'b0;
        check("full_drain_cnt", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++) check("full_drain_word", popped[i], 32'h100 + i);
        rd(8'h04, 32'h80020000, "full_status");
        rd(8'h0C, 32'd16, "full_pushcnt");

        // Flush wins over a same-cycle pop; PUSHCNT untouched
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h00, 32'hA0 + i, 1'b0, "flush_fill");
        rd(8'h04, 32'h00000005, "flush_pre_status");
        wr(8'h08, 32'h2, 1'b1, "flush_wr");
        check("flush_valid", {31'h0, user_valid}, 32'h0);
        user_ready = 1'b0;
        rd(8'h04, 32'h00020000, "flush_status");
        rd(8'h0C, 32'd5, "flush_pushcnt");

        // Reset while a DATA write is in flight
        do_reset();
        @(negedge OPB_Clk);
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b0;
        OPB_BE     = 4'hF;
        OPB_DBus   = 32'h55;
        OPB_select = 1'b1;
        #2 OPB_Rst_n = 1'b0;
        @(posedge OPB_Clk);
        #1;
        check("inflight_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("inflight_valid", {31'h0, user_valid}, 32'h0);
        OPB_select = 1'b0;
        OPB_RNW    = 1'b1;
        @(negedge OPB_Clk) OPB_Rst_n = 1'b1;
        rd(8'h04, 32'h00020000, "inflight_status");
        rd(8'h0C, 32'h0, "inflight_pushcnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
